// File: rtl/stream_rr_arbiter_pkg.sv
// Shared constants for the stream round-robin arbiter and its helpers.
package stream_rr_arbiter_pkg;

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_BURST = 1'b1;

    // Width of the per-grant beat counter; burst caps up to 65535 fit.
    localparam int BEAT_CNT_WIDTH = 16;

    typedef enum logic {
        ST_IDLE  = STATE_IDLE,
        ST_BURST = STATE_BURST
    } state_t;

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index
// strictly above last_grant, wrapping to the lowest requester otherwise.
module rr_pick
    import stream_rr_arbiter_pkg::*;
#(
    parameter int C_NUM_PORTS = 4,
    parameter int C_ID_WIDTH  = 2
) (
    input  logic [C_NUM_PORTS-1:0] req,
    input  logic [C_ID_WIDTH-1:0]  last_grant,
    output logic [C_ID_WIDTH-1:0]  next_idx,
    output logic                   any_req
);

    // Requests sitting above the previous winner get priority this round.
    logic [C_NUM_PORTS-1:0] upper_req;

    for (genvar gi = 0; gi < C_NUM_PORTS; gi++) begin : g_mask
        assign upper_req[gi] = req[gi] & (C_ID_WIDTH'(gi) > last_grant);
    end

    logic [C_ID_WIDTH-1:0] lo_idx;
    logic [C_ID_WIDTH-1:0] hi_idx;

    // Lowest set bit of the masked and unmasked vectors; masked wins if any.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        for (int i = C_NUM_PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = C_ID_WIDTH'(i);
            end
            if (upper_req[i]) begin
                hi_idx = C_ID_WIDTH'(i);
            end
        end
        next_idx = (|upper_req) ? hi_idx : lo_idx;
        any_req  = |req;
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin stream arbiter: grants one requester per packet (capped at
// C_MAX_BURST beats) and forwards beats through one output register,
// tagging each with its source port id.
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter int C_NUM_PORTS  = 4,
    parameter int C_ID_WIDTH   = 2,
    parameter int C_DATA_WIDTH = 64,
    parameter int C_MAX_BURST  = 16
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [C_NUM_PORTS-1:0]            s_valid,
    output logic [C_NUM_PORTS-1:0]            s_ready,
    input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0] s_data,
    input  logic [C_NUM_PORTS-1:0]            s_last,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [C_DATA_WIDTH-1:0]           m_data,
    output logic                              m_last,
    output logic [C_ID_WIDTH-1:0]             m_id,
    output logic                              grant_active
);

    localparam logic [C_ID_WIDTH-1:0]     LAST_PORT = C_ID_WIDTH'(C_NUM_PORTS - 1);
    localparam logic [BEAT_CNT_WIDTH-1:0] CNT_CAP   = BEAT_CNT_WIDTH'(C_MAX_BURST - 1);

    state_t                    state_reg, state_next;
    logic [C_ID_WIDTH-1:0]     grant_reg, grant_next;
    logic [C_ID_WIDTH-1:0]     last_grant_reg, last_grant_next;
    logic [BEAT_CNT_WIDTH-1:0] beat_cnt_reg, beat_cnt_next;

    logic                      m_valid_reg;
    logic [C_DATA_WIDTH-1:0]   m_data_reg;
    logic                      m_last_reg;
    logic [C_ID_WIDTH-1:0]     m_id_reg;

    logic [C_DATA_WIDTH-1:0]   port_data [C_NUM_PORTS];

    for (genvar gi = 0; gi < C_NUM_PORTS; gi++) begin : g_unpack
        assign port_data[gi] = s_data[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
    end

    logic                    in_burst;
    logic                    out_free;
    logic                    xfer;
    logic                    sel_last;
    logic [C_DATA_WIDTH-1:0] sel_data;
    logic [C_ID_WIDTH-1:0]   pick_idx;
    logic                    any_req;

    assign in_burst = (state_reg == ST_BURST);
    // The output register can take a new beat when empty or being drained.
    assign out_free = ~m_valid_reg | m_ready;
    assign sel_data = port_data[grant_reg];
    assign sel_last = s_last[grant_reg];
    assign xfer     = in_burst & s_valid[grant_reg] & out_free;

    for (genvar gi = 0; gi < C_NUM_PORTS; gi++) begin : g_ready
        assign s_ready[gi] = in_burst & (grant_reg == C_ID_WIDTH'(gi)) & out_free;
    end

    rr_pick #(
        .C_NUM_PORTS (C_NUM_PORTS),
        .C_ID_WIDTH  (C_ID_WIDTH)
    ) u_pick (
        .req        (s_valid),
        .last_grant (last_grant_reg),
        .next_idx   (pick_idx),
        .any_req    (any_req)
    );

    // Next-state logic: arbitrate in IDLE, count beats and end grants in BURST.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        beat_cnt_next   = beat_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    grant_next    = pick_idx;
                    beat_cnt_next = '0;
                    state_next    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (xfer) begin
                    // A cap break leaves m_last alone; the packet tail re-arbitrates.
                    if (sel_last || (beat_cnt_reg == CNT_CAP)) begin
                        last_grant_next = grant_reg;
                        state_next      = ST_IDLE;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= LAST_PORT;
            beat_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            beat_cnt_reg   <= beat_cnt_next;
        end
    end

    // Output register: load on transfer, clear valid once the sink accepts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_last_reg  <= 1'b0;
            m_id_reg    <= '0;
        end else if (xfer) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= sel_data;
            m_last_reg  <= sel_last;
            m_id_reg    <= grant_reg;
        end else if (m_ready) begin
            m_valid_reg <= 1'b0;
        end
    end

    assign m_valid      = m_valid_reg;
    assign m_data       = m_data_reg;
    assign m_last       = m_last_reg;
    assign m_id         = m_id_reg;
    assign grant_active = in_burst;

endmodule
